filter_bank_router: RTL and testbench

- Drives a bank of N_FILT AXI-stream FIR filter cores and returns one filtered audio sample per input sample.
- Each input sample is broadcast to every filter so that all delay lines stay warm. The output of the filter chosen by sel is scaled, rounded and saturated to audio width.
- Sits between the audio codec sample path and the playback/effects path. It replaces hard-wired single-filter selection with a parametrised bank.

---
 rtl/filter_bank_pkg.sv | 23 ++
 rtl/audio_sat_round.sv | 31 +++
 rtl/filter_bank_router.sv | 238 +++++++++++++++++++++++
 tb/tb_filter_bank_router.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_bank_pkg.sv
// rtl/filter_bank_pkg.sv - shared state type, default widths and sel-width helper for the filter bank router
package filter_bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        COLLECT,
        OUT
    } state_t;

    localparam int DEF_N_FILT  = 3;
    localparam int DEF_AUDIO_W = 16;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_SHIFT   = 15;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_XF_LOG2 = 6;

    // One code beyond the last filter index is needed for the bypass selection.
    function automatic int sel_width(input int n_filt);
        return $clog2(n_filt + 1);
    endfunction

endpackage

// File: rtl/audio_sat_round.sv
// rtl/audio_sat_round.sv - round-half-up, arithmetic right shift and saturate an accumulator to audio width
module audio_sat_round #(
    parameter int ACC_W   = 32,
    parameter int AUDIO_W = 16,
    parameter int SHIFT   = 15
) (
    input  logic signed [ACC_W-1:0]   acc,
    output logic signed [AUDIO_W-1:0] sample
);

    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((64'sd1 <<< (AUDIO_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    // One guard bit keeps the rounding add from wrapping near full scale.
    always_comb begin
        sum     = $signed({acc[ACC_W-1], acc}) + RND;
        shifted = sum >>> SHIFT;
        if (shifted > MAX_V) begin
            sample = MAX_V[AUDIO_W-1:0];
        end else if (shifted < MIN_V) begin
            sample = MIN_V[AUDIO_W-1:0];
        end else begin
            sample = shifted[AUDIO_W-1:0];
        end
    end

endmodule

// File: rtl/filter_bank_router.sv
// rtl/filter_bank_router.sv - broadcasts each sample to a bank of FIR cores and returns the selected, scaled output
// Optional crossfade on filter switch: define FILTER_XFADE_EN.
module filter_bank_router
    import filter_bank_pkg::*;
#(
    parameter int N_FILT  = DEF_N_FILT,
    parameter int AUDIO_W = DEF_AUDIO_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int XF_LOG2 = DEF_XF_LOG2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [sel_width(N_FILT)-1:0]      sel,
    input  logic                              ready,
    input  logic signed [AUDIO_W-1:0]         audio_in,
    output logic signed [AUDIO_W-1:0]         audio_out,
    output logic                              done,
    output logic                              overrun,
    output logic                              timeout,
    output logic [N_FILT-1:0]                 flt_s_tvalid,
    input  logic [N_FILT-1:0]                 flt_s_tready,
    output logic signed [AUDIO_W-1:0]         flt_s_tdata,
    input  logic [N_FILT-1:0]                 flt_m_tvalid,
    output logic [N_FILT-1:0]                 flt_m_tready,
    input  logic [N_FILT*ACC_W-1:0]           flt_m_tdata
);

    localparam int SEL_W = sel_width(N_FILT);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t                     state;
    state_t                     state_next;
    logic [N_FILT-1:0]          sent_mask;
    logic [N_FILT-1:0]          got_mask;
    logic [N_FILT-1:0]          hs_s;
    logic [N_FILT-1:0]          hs_m;
    logic [SEL_W-1:0]           sel_q;
    logic [WD_W-1:0]            wd;
    logic signed [ACC_W-1:0]    captured;
    logic signed [AUDIO_W-1:0]  sample_q;
    logic signed [AUDIO_W-1:0]  sat_out;
    logic                       new_byp;
    logic                       skip_filters;
    logic                       send_done;
    logic                       collect_done;
    logic                       wd_expired;

    assign flt_s_tdata  = sample_q;
    assign flt_s_tvalid = (state == SEND)    ? ~sent_mask : '0;
    assign flt_m_tready = (state == COLLECT) ? ~got_mask  : '0;
    assign hs_s         = flt_s_tvalid & flt_s_tready;
    assign hs_m         = flt_m_tvalid & flt_m_tready;
    assign send_done    = (sent_mask | hs_s) == '1;
    assign collect_done = (got_mask | hs_m) == '1;
    assign wd_expired   = (wd == WD_W'(TIMEOUT - 1));
    assign new_byp      = (sel >= SEL_W'(N_FILT));

`ifdef FILTER_XFADE_EN
    localparam int K     = 1 << XF_LOG2;
    localparam int MIX_W = ACC_W + XF_LOG2 + 2;

    logic [SEL_W-1:0]           cur_sel;
    logic [SEL_W-1:0]           old_sel;
    logic                       fading;
    logic [XF_LOG2:0]           fade_k;
    logic signed [ACC_W-1:0]    old_cap;
    logic signed [MIX_W-1:0]    w_new;
    logic signed [MIX_W-1:0]    w_old;
    logic signed [MIX_W-1:0]    mix_acc;
    logic signed [MIX_W-1:0]    mix_val;

    // Bypass may skip the bank only when no filter output is needed for the fade.
    always_comb begin
        if (sel != cur_sel) begin
            skip_filters = new_byp && (cur_sel >= SEL_W'(N_FILT));
        end else begin
            skip_filters = new_byp && (!fading || (old_sel >= SEL_W'(N_FILT)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_sel <= '0;
            old_sel <= '0;
            fading  <= 1'b0;
            fade_k  <= '0;
            old_cap <= '0;
        end else begin
            if (state == IDLE && ready) begin
                old_cap <= ACC_W'(audio_in) <<< SHIFT;
                if (sel != cur_sel) begin
                    old_sel <= cur_sel;
                    cur_sel <= sel;
                    fading  <= 1'b1;
                    fade_k  <= (XF_LOG2+1)'(1);
                end
            end
            if (state == COLLECT) begin
                for (int i = 0; i < N_FILT; i++) begin
                    if (hs_m[i] && old_sel == SEL_W'(i)) begin
                        old_cap <= flt_m_tdata[i*ACC_W +: ACC_W];
                    end
                end
            end
            if (state == OUT && fading) begin
                if (fade_k == (XF_LOG2+1)'(K)) begin
                    fading <= 1'b0;
                end else begin
                    fade_k <= fade_k + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_new   = MIX_W'($signed({1'b0, fade_k}));
        w_old   = MIX_W'(K) - w_new;
        mix_acc = MIX_W'(old_cap) * w_old + MIX_W'(captured) * w_new;
        mix_val = fading ? (mix_acc >>> XF_LOG2) : MIX_W'(captured);
    end

    audio_sat_round #(
        .ACC_W  (MIX_W),
        .AUDIO_W(AUDIO_W),
        .SHIFT  (SHIFT)
    ) u_sat (
        .acc   (mix_val),
        .sample(sat_out)
    );
`else
    assign skip_filters = new_byp;

    audio_sat_round #(
        .ACC_W  (ACC_W),
        .AUDIO_W(AUDIO_W),
        .SHIFT  (SHIFT)
    ) u_sat (
        .acc   (captured),
        .sample(sat_out)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completing a phase takes priority over the watchdog in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ready) begin
                    state_next = skip_filters ? OUT : SEND;
                end
            end
            SEND: begin
                if (send_done) begin
                    state_next = COLLECT;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            COLLECT: begin
                if (collect_done) begin
                    state_next = OUT;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sent_mask <= '0;
            got_mask  <= '0;
            sel_q     <= '0;
            wd        <= '0;
            captured  <= '0;
            sample_q  <= '0;
            audio_out <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ready && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ready) begin
                        sample_q  <= audio_in;
                        sel_q     <= sel;
                        sent_mask <= '0;
                        got_mask  <= '0;
                        wd        <= '0;
                        // Bypass value pre-scaled so the shared rounding path returns it unchanged.
                        captured  <= ACC_W'(audio_in) <<< SHIFT;
                    end
                end
                SEND: begin
                    sent_mask <= sent_mask | hs_s;
                    wd        <= wd + 1'b1;
                    if (!send_done && wd_expired) begin
                        timeout <= 1'b1;
                    end
                end
                COLLECT: begin
                    got_mask <= got_mask | hs_m;
                    wd       <= wd + 1'b1;
                    for (int i = 0; i < N_FILT; i++) begin
                        if (hs_m[i] && sel_q == SEL_W'(i)) begin
                            captured <= flt_m_tdata[i*ACC_W +: ACC_W];
                        end
                    end
                    if (!collect_done && wd_expired) begin
                        timeout <= 1'b1;
                    end
                end
                OUT: begin
                    audio_out <= sat_out;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_bank_router.sv
// tb/tb_filter_bank_router.sv - self-checking bench for filter_bank_router with behavioural filter stubs
module tb_filter_bank_router;
    import filter_bank_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int CW = 32;
    localparam int SH = 15;
    localparam int TO = 255;
    localparam int XL = 2;
    localparam int SW = sel_width(N);

    logic                  clock = 1'b0;
    logic                  reset;
    logic [SW-1:0]         sel;
    logic                  ready;
    logic signed [AW-1:0]  audio_in;
    logic signed [AW-1:0]  audio_out;
    logic                  done;
    logic                  overrun;
    logic                  timeout;
    logic [N-1:0]          s_tvalid;
    logic [N-1:0]          s_tready;
    logic signed [AW-1:0]  s_tdata;
    logic [N-1:0]          m_tvalid;
    logic [N-1:0]          m_tready;
    logic [N*CW-1:0]       m_tdata;

    always #5 clock = ~clock;

    filter_bank_router #(
        .N_FILT(N), .AUDIO_W(AW), .ACC_W(CW), .SHIFT(SH), .TIMEOUT(TO), .XF_LOG2(XL)
    ) dut (
        .clock(clock), .reset(reset), .sel(sel), .ready(ready), .audio_in(audio_in),
        .audio_out(audio_out), .done(done), .overrun(overrun), .timeout(timeout),
        .flt_s_tvalid(s_tvalid), .flt_s_tready(s_tready), .flt_s_tdata(s_tdata),
        .flt_m_tvalid(m_tvalid), .flt_m_tready(m_tready), .flt_m_tdata(m_tdata)
    );

    // Filter stubs: one-deep response register, default response is in * 2^SH.
    int              cyc = 0;
    int              stall_until [N] = '{default: 0};
    int              s_hs_cnt [N] = '{default: 0};
    logic [N-1:0]    pend = '0;
    logic [CW-1:0]   pval [N] = '{default: '0};
    logic [N-1:0]    mute_m = '0;
    logic [N-1:0]    ovr_en = '0;
    logic [CW-1:0]   ovr_val [N] = '{default: '0};

    always_comb begin
        s_tready = '0;
        m_tvalid = '0;
        m_tdata  = '0;
        for (int i = 0; i < N; i++) begin
            s_tready[i] = (cyc >= stall_until[i]);
            m_tvalid[i] = pend[i] && !mute_m[i];
            m_tdata[i*CW +: CW] = pval[i];
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                pend[i] <= 1'b0;
            end else if (s_tvalid[i] && s_tready[i]) begin
                pend[i]     <= 1'b1;
                pval[i]     <= ovr_en[i] ? ovr_val[i] : (CW'($signed(s_tdata)) <<< SH);
                s_hs_cnt[i] <= s_hs_cnt[i] + 1;
            end else if (m_tvalid[i] && m_tready[i]) begin
                pend[i] <= 1'b0;
            end
        end
    end

    // Scoreboard: expectations queued at stimulus, DUT results collected on done.
    logic signed [AW-1:0] exp_q [$];
    logic signed [AW-1:0] got_q [$];
    int                   got_rd = 0;
    int                   done_cnt = 0;

    always @(negedge clock) begin
        if (done) begin
            got_q.push_back(audio_out);
            done_cnt = done_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_sb(input string name);
        #1;
        check({name, "_count"}, got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            check(name, got_q[got_rd], exp_q.pop_front());
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    task automatic start(input logic [SW-1:0] s, input logic signed [AW-1:0] a);
        @(posedge clock); #1;
        sel = s; audio_in = a; ready = 1'b1;
        @(posedge clock); #1;
        ready = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic overrun_pair(input int gap);
        int base;
        base = done_cnt;
        exp_q.push_back(16'sd111);
        @(posedge clock); #1;
        sel = '0; audio_in = 16'sd111; ready = 1'b1;
        @(posedge clock); #1;
        ready = 1'b0; audio_in = 16'sd222;
        repeat (gap - 1) @(posedge clock);
        #1 ready = 1'b1;
        @(posedge clock); #1;
        ready = 1'b0;
        repeat (10) @(negedge clock);
        check_sb($sformatf("overrun_gap%0d_out", gap));
        check($sformatf("overrun_gap%0d_dones", gap), done_cnt - base, 1);
        check($sformatf("overrun_gap%0d_flag", gap), overrun, 1);
    endtask

    typedef struct {
        logic [SW-1:0]         s;
        logic signed [AW-1:0]  a;
        bit                    ovr;
        logic [CW-1:0]         ov;
        logic signed [AW-1:0]  exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int lat;
        int base;
        int hs0 [N];
        logic signed [AW-1:0] held;
        bit byp;

        vecs[0] = '{2'd0, 16'sd1000,   1'b0, 32'h0000_0000, 16'sd1000};
        vecs[1] = '{2'd1, -16'sd1234,  1'b0, 32'h0000_0000, -16'sd1234};
        vecs[2] = '{2'd2, 16'sd32767,  1'b0, 32'h0000_0000, 16'sd32767};
        vecs[3] = '{2'd2, 16'sd5,      1'b1, 32'h7FFF_FFFF, 16'sd32767};
        vecs[4] = '{2'd2, 16'sd5,      1'b1, 32'h8000_0000, -16'sd32768};
        vecs[5] = '{2'd0, 16'sd5,      1'b1, 32'h0000_4000, 16'sd1};
        vecs[6] = '{2'd1, 16'sd5,      1'b1, 32'h0000_3FFF, 16'sd0};
        vecs[7] = '{2'd0, 16'sd5,      1'b1, 32'hFFFF_C000, 16'sd0};
        vecs[8] = '{2'd3, -16'sd5,     1'b0, 32'h0000_0000, -16'sd5};
        vecs[9] = '{2'd3, 16'sd32767,  1'b1, 32'h1234_5678, 16'sd32767};

        reset = 1'b1; ready = 1'b0; sel = '0; audio_in = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_audio_out", audio_out, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_s_tvalid", s_tvalid, 0);
        check("rst_m_tready", m_tready, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < N; i++) begin
                ovr_en[i]  = vecs[v].ovr;
                ovr_val[i] = vecs[v].ov;
                hs0[i]     = s_hs_cnt[i];
            end
            byp = (vecs[v].s >= SW'(N));
            exp_q.push_back(vecs[v].exp);
            start(vecs[v].s, vecs[v].a);
            wait_done(lat);
            check_sb($sformatf("vec%0d_out", v));
            if (byp) check($sformatf("vec%0d_bypass_latency", v), lat, 2);
            for (int i = 0; i < N; i++)
                check($sformatf("vec%0d_hs%0d", v, i), s_hs_cnt[i] - hs0[i], byp ? 0 : 1);
        end
        ovr_en = '0;

        // Filter 1 stalls its input; the others must complete first.
        for (int i = 0; i < N; i++) hs0[i] = s_hs_cnt[i];
        stall_until[1] = cyc + 10;
        exp_q.push_back(16'sd300);
        start(2'd1, 16'sd300);
        @(negedge clock);
        @(negedge clock);
        check("stall_tvalid_early", s_tvalid, 3'b010);
        repeat (3) @(negedge clock);
        check("stall_tvalid_held", s_tvalid, 3'b010);
        wait_done(lat);
        check_sb("stall_out");
        check("stall_timeout", timeout, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("stall_hs%0d", i), s_hs_cnt[i] - hs0[i], 1);

        // Filter 2 never responds: watchdog aborts.
        held = audio_out;
        base = done_cnt;
        mute_m[2] = 1'b1;
        start(2'd0, 16'sd500);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            if (timeout) begin
                lat = n;
                break;
            end
        end
        check("timeout_latency", lat, TO + 1);
        check("timeout_no_done", done_cnt - base, 0);
        check("timeout_audio_held", audio_out, held);
        check("timeout_s_tvalid", s_tvalid, 0);
        check("timeout_m_tready", m_tready, 0);
        check_sb("timeout_out");
        mute_m[2] = 1'b0;
        exp_q.push_back(16'sd77);
        start(2'd2, 16'sd77);
        wait_done(lat);
        check_sb("after_timeout_out");
        check("timeout_sticky", timeout, 1);

        do_reset();
        check("reset_clears_timeout", timeout, 0);
        overrun_pair(2);
        do_reset();
        check("reset_clears_overrun", overrun, 0);
        overrun_pair(3);

        // Reset in the middle of a transaction: no done, outputs back to reset values.
        base = done_cnt;
        start(2'd1, 16'sd900);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("midreset_no_done", done_cnt - base, 0);
        check("midreset_audio_out", audio_out, 0);
        check("midreset_overrun", overrun, 0);
        check_sb("midreset_out");

        // Switch from filter 0 (output 0) to filter 1 (output 4000).
        do_reset();
        ovr_en = '1;
        ovr_val[0] = 32'd0;
        ovr_val[1] = 32'd4000 << SH;
        ovr_val[2] = 32'd0;
        exp_q.push_back(16'sd0);
        start(2'd0, 16'sd1);
        wait_done(lat);
        check_sb("switch_pre");
        for (int j = 0; j < 4; j++) begin
`ifdef FILTER_XFADE_EN
            exp_q.push_back(AW'(1000 * (j + 1)));
`else
            exp_q.push_back(16'sd4000);
`endif
            start(2'd1, 16'sd1);
            wait_done(lat);
            check_sb($sformatf("switch_%0d", j));
        end
        ovr_en = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
